// File: rtl/result_buffer_pkg.sv
// rtl/result_buffer_pkg.sv - shared constants and width helpers for result_buffer
package result_buffer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int DROP_CNT_W = 16;

    // Pointer width for a power-of-two depth; never narrower than one bit
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Level must represent 0..depth inclusive, hence one extra bit
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [ptr_w(DEPTH_DEF)-1:0]   ptr_t;
    typedef logic [level_w(DEPTH_DEF)-1:0] level_t;

endpackage

// File: rtl/result_buffer_mem.sv
// rtl/result_buffer_mem.sv - DEPTH x DATA_W register array, one write port, one async read port
module result_buffer_mem
    import result_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
)
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [ptr_w(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage carries no reset; validity is tracked by the pointer logic
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/result_buffer.sv
// rtl/result_buffer.sv - result FIFO with sticky overflow; optional drop counter under RESULT_BUFFER_STATS_EN
module result_buffer
    import result_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
)
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        dv_in,
    input  logic [DATA_W-1:0]           data_in,
    output logic                        valid_out,
    output logic [DATA_W-1:0]           data_out,
    input  logic                        ready_in,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        full,
    output logic                        overflow,
    input  logic                        clr_ovf
`ifdef RESULT_BUFFER_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]       drop_cnt
`endif
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [DATA_W-1:0] rd_data;
    logic              pop;
    logic              push;
    logic              drop;

    assign valid_out = (level_q != '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign level     = level_q;
    assign pop       = valid_out & ready_in;
    // A full buffer still accepts when the head leaves in the same cycle
    assign push      = dv_in & (~full | pop);
    assign drop      = dv_in & full & ~pop;
    // Empty buffer presents zero so data_out is defined out of reset
    assign data_out  = valid_out ? rd_data : '0;

    result_buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr),
        .wdata  (data_in),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef RESULT_BUFFER_STATS_EN
    // Saturating drop counter; clear plus drop in one cycle counts that drop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_result_buffer.sv
// tb/tb_result_buffer.sv - randomized self-checking bench for result_buffer against a queue model
module tb_result_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dv_in;
    logic [31:0] data_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic        ready_in;
    logic [2:0]  level;
    logic        full;
    logic        overflow;
    logic        clr_ovf;
`ifdef RESULT_BUFFER_STATS_EN
    logic [15:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [31:0] q[$];
    bit          m_ovf;
    int          m_cnt;

    always #5 clk = ~clk;

    result_buffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dv_in     (dv_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .level     (level),
        .full      (full),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef RESULT_BUFFER_STATS_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a plain FIFO queue with drop-on-full and sticky flag
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            bit p_pop, p_push, p_drop;
            p_pop  = (q.size() != 0) && ready_in;
            p_push = dv_in && ((q.size() < DEPTH) || p_pop);
            p_drop = dv_in && !p_push;
            if (p_pop) void'(q.pop_front());
            if (p_push) q.push_back(data_in);
            if (p_drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (clr_ovf) m_cnt = p_drop ? 1 : 0;
            else if (p_drop && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    end

    // Every negedge: DUT outputs must match the queue model
    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            check("m_valid", valid_out, q.size() != 0);
            check("m_level", level, q.size());
            check("m_full", full, q.size() == DEPTH);
            check("m_ovf", overflow, m_ovf);
            if (q.size() != 0) check("m_data", data_out, q[0]);
`ifdef RESULT_BUFFER_STATS_EN
            check("m_cnt", drop_cnt, m_cnt);
`endif
        end
    end

    task automatic cyc(input logic dv, input logic [31:0] d, input logic rdy, input logic clr);
        dv_in = dv; data_in = d; ready_in = rdy; clr_ovf = clr;
        @(negedge clk);
    endtask

    task automatic fill4();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    endtask

    task automatic drain_expect(input int first, input int last_v, input string name);
        for (int i = first; i <= last_v; i++) begin
            check(name, data_out, 32'(i));
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check({name, "_empty"}, valid_out, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; dv_in = 1'b0; data_in = '0; ready_in = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Reset state
        check("rst_valid", valid_out, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_data", data_out, 32'h0);

        // Single pass-through
        cyc(1'b1, 32'h0000_0007, 1'b1, 1'b0);
        check("pass_valid", valid_out, 1'b1);
        check("pass_data", data_out, 32'h7);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("pass_level", level, 3'd0);

        // Fill and order
        fill4();
        check("fill_full", full, 1'b1);
        check("fill_level", level, 3'd4);
        drain_expect(1, 4, "order");

        // Overflow, clear colliding with drop, then clear
        fill4();
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_level", level, 3'd4);
`ifdef RESULT_BUFFER_STATS_EN
        check("ovf_cnt", drop_cnt, 16'd1);
`endif
        cyc(1'b1, 32'h0000_0ABC, 1'b0, 1'b1);
        check("ovf_setwins", overflow, 1'b1);
`ifdef RESULT_BUFFER_STATS_EN
        check("ovf_cnt_clr_inc", drop_cnt, 16'd1);
`endif
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check("ovf_clr", overflow, 1'b0);
        drain_expect(1, 4, "ovf_drain");

        // Simultaneous push and pop at full
        fill4();
        cyc(1'b1, 32'h5, 1'b1, 1'b0);
        check("simul_level", level, 3'd4);
        check("simul_ovf", overflow, 1'b0);
        drain_expect(2, 5, "simul_drain");

        // Wrap-around with push/pop at level 1
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'(i), 1'b1, 1'b0);
            check("wrap_data", data_out, 32'(i));
            check("wrap_level", level, 3'd1);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("wrap_empty", level, 3'd0);

        // Async reset mid-stream
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(100 + i), 1'b0, 1'b0);
        check("ar_level3", level, 3'd3);
        dv_in = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("ar_valid", valid_out, 1'b0);
        check("ar_level", level, 3'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("ar_idle", valid_out, 1'b0);
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check("ar_first_valid", valid_out, 1'b1);
        check("ar_first_data", data_out, 32'h1234_5678);

        // Randomized traffic in phases of varying consumer readiness
        for (int ph = 0; ph < 8; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 2 == 0) ? 20 : 75;
            for (int c = 0; c < 100; c++) begin
                cyc($urandom_range(0, 99) < 60,
                    $urandom,
                    $urandom_range(0, 99) < rdy_pct,
                    $urandom_range(0, 15) == 0);
            end
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the result word width.
REQ-002 SHALL have parameter DEPTH, default 4, the number of buffer entries; must be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port dv_in, input, 1 bit: a one-cycle result-valid strobe from the adder stage (its dv_out); no backpressure upstream.
REQ-006 SHALL have port data_in, input, DATA_W bits: the result word, sampled when dv_in=1.
REQ-007 SHALL have port valid_out, output, 1 bit: the head entry is presented on data_out.
REQ-008 SHALL have port data_out, output, DATA_W bits: the head result word.
REQ-009 SHALL have port ready_in, input, 1 bit: the consumer accepts; a pop occurs when valid_out && ready_in.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1 bits: the number of stored entries.
REQ-011 SHALL have port full, output, 1 bit: level==DEPTH.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a result is dropped.
REQ-013 SHALL have port clr_ovf, input, 1 bit: a synchronous clear of overflow.

Function
REQ-014 A push SHALL occur when dv_in=1 and (level<DEPTH or a pop occurs in the same cycle).
REQ-015 A pushed word SHALL be written at wr_ptr; wr_ptr SHALL increment modulo DEPTH.
REQ-016 A pop SHALL advance rd_ptr modulo DEPTH.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-018 Latency SHALL be 1 cycle: a word pushed at edge N into an empty buffer has valid_out=1 and data_out=word after edge N.
REQ-019 data_out SHALL equal mem[rd_ptr] and be stable while valid_out=1 and ready_in=0.
REQ-020 valid_out SHALL equal (level!=0).
REQ-021 Push and pop in the same cycle SHALL leave level unchanged, including when level==DEPTH and when level==1.
REQ-022 dv_in=1 with level==DEPTH and no pop SHALL drop the word and set overflow; stored contents and pointers SHALL be unchanged.
REQ-023 If clr_ovf and a drop coincide, the set SHALL win (overflow stays 1).
REQ-024 ready_in with level==0 SHALL be ignored.
REQ-025 data_in values SHALL be stored unmodified; DATA_W bits SHALL be carried with no truncation.

Reset
REQ-026 reset_n=0 SHALL asynchronously force wr_ptr=0, rd_ptr=0, level=0, valid_out=0, full=0 and overflow=0.
REQ-027 data_out SHALL reset to 0.
REQ-028 Memory contents SHALL need no reset.
REQ-029 Reset asserted mid-operation SHALL discard all entries.
REQ-030 The first push after reset_n deassertion SHALL behave per REQ-018.

Configuration
REQ-031 With the macro RESULT_BUFFER_STATS_EN defined, the block SHALL add output drop_cnt, 16 bits.
REQ-032 drop_cnt SHALL increment on each drop (REQ-022) and saturate at 16'hFFFF.
REQ-033 drop_cnt SHALL be cleared by reset_n=0 or by clr_ovf (an increment in the same cycle as clr_ovf yields 1).
REQ-034 Without RESULT_BUFFER_STATS_EN, the drop_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-035 A shared package result_buffer_pkg SHALL hold DATA_W_DEF=32, DEPTH_DEF=4, the DROP_CNT_W=16 constant, and the ptr_t/level_t width helpers.
REQ-036 Storage SHALL be a sub-module result_buffer_mem: a DEPTH x DATA_W register array, 1 write port, 1 asynchronous read port.
REQ-037 Pointer, level and flag logic SHALL live in result_buffer.

Verification
REQ-038 Scenario "single pass-through": reset; dv_in pulse with data_in=32'h0000_0007, ready_in=1 -> valid_out=1, data_out=7 one cycle later; level returns to 0 the cycle after the pop.
REQ-039 Scenario "fill and order": ready_in=0; push 1,2,3,4 -> full=1, level=4; then ready_in=1 -> data_out 1,2,3,4 on consecutive cycles; valid_out=0 afterwards.
REQ-040 Scenario "overflow": with the buffer full, push 32'hDEAD_BEEF with ready_in=0 -> overflow=1, level=4, and the drained contents exclude DEAD_BEEF; with RESULT_BUFFER_STATS_EN defined, drop_cnt=1; clr_ovf -> overflow=0.
REQ-041 Scenario "simultaneous at full": full, with dv_in=1 (data 5) and ready_in=1 in the same cycle -> level stays 4, overflow stays 0, and 5 is drained last.
REQ-042 Scenario "wrap-around": 10 push/pop pairs with values 0..9 -> output 0..9 in order; pointers wrap twice.
REQ-043 Scenario "async reset mid-stream": at level=3, pulse reset_n low between edges -> valid_out=0 and level=0 immediately, with no outputs after release until a new push.
